fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master is its surrounding pipeline.
interface fetch_stage_if;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        output start, stall, redirect_valid, redirect_pc, imem_inst,
        input  imem_addr, ifid_pc, ifid_inst, ifid_valid, halted, fetch_count
    );

    modport slave (
        input  start, stall, redirect_valid, redirect_pc, imem_inst,
        output imem_addr, ifid_pc, ifid_inst, ifid_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses inst_mem combinationally and fills IF/ID.
// state | meaning
// IDLE  | after reset, waiting for start; IF/ID holds a bubble
// RUN   | fetching; redirect > stall > halt word > normal fetch
// HALT  | halt word seen; everything frozen until reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_INST = 32'h00000000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 32'd0;
            ifid_inst_q   <= 32'd0;
            ifid_valid_q  <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_inst_q   <= ifid_inst_d;
            ifid_valid_q  <= ifid_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_inst_d   = ifid_inst_q;
        ifid_valid_d  = ifid_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // Flush the wrong-path instruction; the target is fetched next cycle.
                    pc_d         = bus.redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = 32'd0;
                end else if (bus.stall) begin
                    // hold everything
                end else if (bus.imem_inst == HALT_INST) begin
                    ifid_valid_d = 1'b0;
                    halted_d     = 1'b1;
                    state_d      = HALT;
                end else begin
                    ifid_pc_d     = pc_q;
                    ifid_inst_d   = bus.imem_inst;
                    ifid_valid_d  = 1'b1;
                    pc_d          = pc_q + 32'd1;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            HALT: begin
                // frozen until reset
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_addr   = pc_q[7:0];
    assign bus.ifid_pc     = ifid_pc_q;
    assign bus.ifid_inst   = ifid_inst_q;
    assign bus.ifid_valid  = ifid_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default DUT (RESET_PC=0) and a second one
// starting at 255 to exercise the address wrap.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [256];

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    always #5 clk = ~clk;

    assign bus.imem_inst  = mem[bus.imem_addr];
    assign bus2.imem_inst = mem2[bus2.imem_addr];

    fetch_stage #(.RESET_PC(32'd0), .HALT_INST(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_stage #(.RESET_PC(32'd255), .HALT_INST(32'h0)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.halted !== 1'b0 || bus.fetch_count !== 32'd0 ||
            bus.ifid_pc !== 32'd0 || bus.ifid_inst !== 32'd0 || bus.imem_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset: valid=%b halted=%b cnt=%0d pc=%h inst=%h addr=%0d expected all zero",
                     bus.ifid_valid, bus.halted, bus.fetch_count, bus.ifid_pc, bus.ifid_inst, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_inst [4];
        exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33; exp_inst[3] = 32'h44;
        do_reset();
        do_start();
        chk32("seq_first_addr", {24'd0, bus.imem_addr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.ifid_inst !== exp_inst[i] || bus.ifid_pc !== i || bus.ifid_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch[%0d]: inst=%h pc=%0d valid=%b expected inst=%h pc=%0d valid=1",
                         i, bus.ifid_inst, bus.ifid_pc, bus.ifid_valid, exp_inst[i], i);
            end
        end
        step();
        chk32("halt_valid", {31'd0, bus.ifid_valid}, 32'd0);
        chk32("halt_flag", {31'd0, bus.halted}, 32'd1);
        chk32("halt_count", bus.fetch_count, 32'd4);
        chk32("halt_pc", {24'd0, bus.imem_addr}, 32'd4);
        // start/stall/redirect must not disturb HALT
        bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd20; bus.stall = 1'b1;
        step(); step();
        bus.start = 1'b0; bus.redirect_valid = 1'b0; bus.stall = 1'b0;
        checks++;
        if (bus.halted !== 1'b1 || bus.imem_addr !== 8'd4 || bus.ifid_valid !== 1'b0 ||
            bus.fetch_count !== 32'd4 || bus.ifid_pc !== 32'd3 || bus.ifid_inst !== 32'h44) begin
            failures++;
            $display("FAIL halt_hold: halted=%b addr=%0d valid=%b cnt=%0d pc=%0d inst=%h expected 1,4,0,4,3,44",
                     bus.halted, bus.imem_addr, bus.ifid_valid, bus.fetch_count, bus.ifid_pc, bus.ifid_inst);
        end
    endtask

    task automatic test_stall();
        do_reset();
        do_start();
        step(); step();
        chk32("pre_stall_inst", bus.ifid_inst, 32'h22);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.ifid_inst !== 32'h22 || bus.imem_addr !== 8'd2 || bus.fetch_count !== 32'd2 ||
                bus.ifid_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: inst=%h addr=%0d cnt=%0d valid=%b expected 22,2,2,1",
                         i, bus.ifid_inst, bus.imem_addr, bus.fetch_count, bus.ifid_valid);
            end
        end
        bus.stall = 1'b0;
        step();
        chk32("stall_resume_inst", bus.ifid_inst, 32'h33);
        chk32("stall_resume_cnt", bus.fetch_count, 32'd3);
    endtask

    task automatic test_redirect();
        do_reset();
        do_start();
        step(); step(); step();
        chk32("pre_redirect_pc", {24'd0, bus.imem_addr}, 32'd3);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd10; bus.stall = 1'b1;
        step();
        bus.redirect_valid = 1'b0; bus.stall = 1'b0;
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 8'd10 || bus.ifid_inst !== 32'd0 ||
            bus.fetch_count !== 32'd3) begin
            failures++;
            $display("FAIL redirect_flush: valid=%b addr=%0d inst=%h cnt=%0d expected 0,10,0,3",
                     bus.ifid_valid, bus.imem_addr, bus.ifid_inst, bus.fetch_count);
        end
        step();
        checks++;
        if (bus.ifid_pc !== 32'd10 || bus.ifid_inst !== 32'hAA || bus.ifid_valid !== 1'b1 ||
            bus.fetch_count !== 32'd4) begin
            failures++;
            $display("FAIL redirect_target: pc=%0d inst=%h valid=%b cnt=%0d expected 10,aa,1,4",
                     bus.ifid_pc, bus.ifid_inst, bus.ifid_valid, bus.fetch_count);
        end
    endtask

    task automatic test_wrap();
        bus2.start = 1'b0; bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'd0;
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        chk32("wrap_reset_addr", {24'd0, bus2.imem_addr}, 32'd255);
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        step();
        chk32("wrap_inst_a", bus2.ifid_inst, 32'hA);
        chk32("wrap_pc_255", bus2.ifid_pc, 32'd255);
        chk32("wrap_addr_0", {24'd0, bus2.imem_addr}, 32'd0);
        step();
        chk32("wrap_inst_b", bus2.ifid_inst, 32'hB);
        chk32("wrap_pc_256", bus2.ifid_pc, 32'd256);
    endtask

    task automatic test_midrun_reset();
        do_reset();
        do_start();
        step(); step(); step();
        chk32("midrun_cnt", bus.fetch_count, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'd0 || bus.ifid_inst !== 32'd0 ||
            bus.fetch_count !== 32'd0 || bus.halted !== 1'b0 || bus.imem_addr !== 8'd0) begin
            failures++;
            $display("FAIL midrun_reset: valid=%b pc=%h inst=%h cnt=%0d halted=%b addr=%0d expected zeros",
                     bus.ifid_valid, bus.ifid_pc, bus.ifid_inst, bus.fetch_count, bus.halted, bus.imem_addr);
        end
        step(); step();
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 8'd0 || bus.fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL midrun_idle: valid=%b addr=%0d cnt=%0d expected 0,0,0",
                     bus.ifid_valid, bus.imem_addr, bus.fetch_count);
        end
        do_start();
        step();
        chk32("midrun_restart", bus.ifid_inst, 32'h11);
    endtask

    task automatic test_prestart();
        do_reset();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd50; bus.stall = 1'b1;
        step(); step();
        bus.redirect_valid = 1'b0; bus.stall = 1'b0;
        checks++;
        if (bus.imem_addr !== 8'd0 || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'd0 ||
            bus.ifid_inst !== 32'd0 || bus.fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL prestart: addr=%0d valid=%b pc=%h inst=%h cnt=%0d expected zeros",
                     bus.imem_addr, bus.ifid_valid, bus.ifid_pc, bus.ifid_inst, bus.fetch_count);
        end
        // still idle: fetch must start from RESET_PC, not the ignored redirect target
        do_start();
        step();
        chk32("prestart_first_pc", bus.ifid_pc, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h100 + i;
            mem2[i] = 32'h200 + i;
        end
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'h0;  mem[10] = 32'hAA;
        mem2[255] = 32'hA; mem2[0] = 32'hB;
        bus.start = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
        bus2.start = 1'b0; bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'd0;
        rst = 1'b1;
        rst2 = 1'b1;
        step();

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_midrun_reset();
        test_prestart();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
